vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 99 +++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// sync/blank decode, packed onto a single 40-bit bus plus a frame-start strobe.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 23,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic                     en,
  output logic [`VGA_BUS_SIZE-1:0] vga_out,
  output logic                     frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS      = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
  localparam logic [11:0] HS_START   = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END     = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END     = 12'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [11:0] hcount_r;
  logic [11:0] vcount_r;
  logic        hs_r;
  logic        hblnk_r;
  logic        vs_r;
  logic        vblnk_r;
  logic        frame_start_r;

  logic [11:0] h_next;
  logic [11:0] v_next;
  logic        h_wrap;
  logic        hs_next;
  logic        hblnk_next;
  logic        vs_next;
  logic        vblnk_next;

  // Flags are decoded from the *next* counter values so that, once registered,
  // they land in the same cycle as the counts they describe.
  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path can
    // leave it unassigned and infer a latch.
    h_wrap = (hcount_r == H_LAST);
    h_next = h_wrap ? 12'd0 : hcount_r + 12'd1;
    v_next = vcount_r;
    if (h_wrap) begin
      v_next = (vcount_r == V_LAST) ? 12'd0 : vcount_r + 12'd1;
    end

    hblnk_next = (h_next >= H_VIS);
    vblnk_next = (v_next >= V_VIS);
    hs_next    = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_next    = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      hcount_r      <= 12'd0;
      vcount_r      <= 12'd0;
      hs_r          <= ~SYNC_POL;
      hblnk_r       <= 1'b0;
      vs_r          <= ~SYNC_POL;
      vblnk_r       <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (en) begin
      hcount_r      <= h_next;
      vcount_r      <= v_next;
      hs_r          <= hs_next;
      hblnk_r       <= hblnk_next;
      vs_r          <= vs_next;
      vblnk_r       <= vblnk_next;
      frame_start_r <= (h_next == 12'd0) && (v_next == 12'd0);
    end else begin
      // Held cycles keep position but must not repeat the frame strobe.
      frame_start_r <= 1'b0;
    end
  end

  assign vga_out     = {hcount_r, hs_r, hblnk_r, vcount_r, vs_r, vblnk_r, 12'h000};
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default timing at both sync polarities
// plus a reduced raster that exercises whole frames in a few hundred cycles.
module tb_vga_timing_gen;

  typedef struct {
    string       tag;
    logic [39:0] bus_a;
    logic        fs_a;
    logic [39:0] bus_b;
    logic        fs_b;
    logic [39:0] bus_c;
    logic        fs_c;
  } exp_t;

  logic        pclk;
  logic        rst;
  logic        en;
  logic [39:0] vga_out_a, vga_out_b, vga_out_c;
  logic        frame_start_a, frame_start_b, frame_start_c;

  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: dut a/b share default timing, dut c is the small raster.
  int h_a = 0, v_a = 0, h_c = 0, v_c = 0;
  bit fs_a = 0, fs_c = 0;
  bit in_reset = 1;

  vga_timing_gen dut_a (
    .pclk(pclk), .rst(rst), .en(en), .vga_out(vga_out_a), .frame_start(frame_start_a)
  );

  vga_timing_gen #(.SYNC_POL(1'b0)) dut_b (
    .pclk(pclk), .rst(rst), .en(en), .vga_out(vga_out_b), .frame_start(frame_start_b)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
  ) dut_c (
    .pclk(pclk), .rst(rst), .en(en), .vga_out(vga_out_c), .frame_start(frame_start_c)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  function automatic logic [39:0] make_bus(input int h, input int v,
                                           input int hvis, input int hs0, input int hs1,
                                           input int vvis, input int vs0, input int vs1,
                                           input bit pol);
    logic hb, vb, hsv, vsv;
    hb  = (h >= hvis);
    vb  = (v >= vvis);
    hsv = (h >= hs0 && h < hs1) ? pol : !pol;
    vsv = (v >= vs0 && v < vs1) ? pol : !pol;
    return {12'(h), hsv, hb, 12'(v), vsv, vb, 12'h000};
  endfunction

  function automatic logic [39:0] reset_bus(input bit pol);
    return {12'd0, !pol, 1'b0, 12'd0, !pol, 1'b0, 12'h000};
  endfunction

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag = tag;
    if (in_reset) begin
      e.bus_a = reset_bus(1'b1);
      e.bus_b = reset_bus(1'b0);
      e.bus_c = reset_bus(1'b1);
    end else begin
      e.bus_a = make_bus(h_a, v_a, 800, 840, 968, 600, 601, 605, 1'b1);
      e.bus_b = make_bus(h_a, v_a, 800, 840, 968, 600, 601, 605, 1'b0);
      e.bus_c = make_bus(h_c, v_c, 8, 10, 13, 4, 5, 7, 1'b1);
    end
    e.fs_a = fs_a;
    e.fs_b = fs_a;
    e.fs_c = fs_c;
    exp_q.push_back(e);
  endtask

  task automatic advance(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  task automatic clear_model();
    h_a = 0; v_a = 0; h_c = 0; v_c = 0;
    fs_a = 0; fs_c = 0;
  endtask

  // One clock of stimulus: drive on the falling edge, predict the post-edge state.
  task automatic cycle(input bit rst_v, input bit en_v, input string tag);
    @(negedge pclk);
    rst = rst_v;
    en  = en_v;
    if (rst_v) begin
      in_reset = 1;
      clear_model();
    end else begin
      in_reset = 0;
      if (en_v) begin
        advance(h_a, v_a, 1056, 628);
        advance(h_c, v_c, 15, 8);
        fs_a = (h_a == 0 && v_a == 0);
        fs_c = (h_c == 0 && v_c == 0);
      end else begin
        fs_a = 0;
        fs_c = 0;
      end
    end
    push_expect(tag);
  endtask

  // Reset raised between edges must show on the bus without any clock.
  task automatic async_reset_mid_cycle();
    @(posedge pclk);
    #3;
    rst = 1'b1;
    in_reset = 1;
    clear_model();
    push_expect("async_rst");
    ->sample_ev;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation is consumed per sampling point, #1 past the trigger.
  logic prev_vs_c = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, "/bus_a"}, vga_out_a, e.bus_a);
        check({e.tag, "/fs_a"}, 40'(frame_start_a), 40'(e.fs_a));
        check({e.tag, "/bus_b"}, vga_out_b, e.bus_b);
        check({e.tag, "/fs_b"}, 40'(frame_start_b), 40'(e.fs_b));
        check({e.tag, "/bus_c"}, vga_out_c, e.bus_c);
        check({e.tag, "/fs_c"}, 40'(frame_start_c), 40'(e.fs_c));
        if (vga_out_c[13] !== prev_vs_c) begin
          check({e.tag, "/vs_edge_hcount_c"}, 40'(vga_out_c[39:28]), 40'd0);
        end
        prev_vs_c = vga_out_c[13];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst = 1'b1;
    en  = 1'b0;

    repeat (3) cycle(1'b1, 1'b0, "reset_hold");
    repeat (2) cycle(1'b1, 1'b1, "reset_hold_en");

    // Release: first counting edge presents hcount=1.
    cycle(1'b0, 1'b1, "release");

    // Full default line plus the wrap into line 1; small raster runs several frames.
    repeat (1060) cycle(1'b0, 1'b1, "line_run");

    guard = 0;
    while (h_a != 500 && guard < 2000) begin
      cycle(1'b0, 1'b1, "to_500");
      guard++;
    end
    check("reach_h500", 40'(h_a), 40'd500);

    repeat (50) cycle(1'b0, 1'b0, "en_hold");
    repeat (20) cycle(1'b0, 1'b1, "en_resume");
    repeat (3) begin
      cycle(1'b0, 1'b0, "en_blip_lo");
      cycle(1'b0, 1'b1, "en_blip_hi");
    end

    guard = 0;
    while (h_a != 900 && guard < 2000) begin
      cycle(1'b0, 1'b1, "to_900");
      guard++;
    end
    check("reach_h900", 40'(h_a), 40'd900);

    async_reset_mid_cycle();
    repeat (3) cycle(1'b1, 1'b1, "rst_hold2");
    cycle(1'b0, 1'b1, "release2");
    repeat (250) cycle(1'b0, 1'b1, "post_reset_run");

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge pclk);
      guard++;
    end
    check("scoreboard_drained", 40'(exp_q.size()), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
